// File: rtl/i4003x_shiftreg.sv
// i4003x_shiftreg: cascadable serial-in/parallel-out shift register clocked by a
// synchronised cp falling edge, with frame counting and an optional output latch.
module i4003x_shiftreg #(
  parameter int WIDTH = 10,
  parameter int STAGES = 1,
  parameter bit LATCHED = 1'b1,
  localparam int N = WIDTH * STAGES,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          sysclk,
  input  logic          poc_n,
  input  logic          cp,
  input  logic          serial_in,
  input  logic          dir,
  input  logic          load,
  input  logic [N-1:0]  parallel_in,
  input  logic          strobe,
  input  logic          enable,
  output logic [N-1:0]  parallel_out,
  output logic          serial_out,
  output logic          frame_done,
  output logic [CW-1:0] shift_count
);
  logic [1:0] rst_sync;
  logic rst_n, s1, s2, s3, shift_pulse;
  logic [N-1:0] sr, latch, sr_shift;
  // Reset asserts immediately but releases on a sysclk edge.
  always_ff @(posedge sysclk or negedge poc_n)
    if (!poc_n) rst_sync <= '0;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign rst_n = rst_sync[1];
  assign shift_pulse = s3 & ~s2;
  generate
    if (N == 1) begin : g_one
      assign sr_shift = serial_in;
    end else begin : g_multi
      assign sr_shift = dir ? {serial_in, sr[N-1:1]} : {sr[N-2:0], serial_in};
    end
  endgenerate
  always_ff @(posedge sysclk or negedge rst_n)
    if (!rst_n) begin
      {s3, s2, s1} <= '0;
      sr <= '0;
      latch <= '0;
      shift_count <= '0;
      frame_done <= 1'b0;
    end else begin
      {s3, s2, s1} <= {s2, s1, cp};
      frame_done <= 1'b0;
      if (strobe) latch <= sr;
      if (load) begin
        sr <= parallel_in;
        shift_count <= '0;
      end else if (shift_pulse) begin
        sr <= sr_shift;
        shift_count <= (shift_count == CW'(N - 1)) ? '0 : shift_count + CW'(1);
        frame_done <= shift_count == CW'(N - 1);
      end
    end
  assign parallel_out = enable ? (LATCHED ? latch : sr) : '0;
  assign serial_out = dir ? sr[0] : sr[N-1];
endmodule

// File: tb/tb_i4003x_shiftreg.sv
// tb_i4003x_shiftreg: scoreboard bench for a latched 10-bit unit and a legacy
// 20-bit cascade, driven from shared stimulus against an arithmetic model.
module tb_i4003x_shiftreg;
  logic sysclk = 0, poc_n = 0, cp = 0, serial_in = 0, dir = 0, load = 0, strobe = 0, enable = 0;
  logic [19:0] parallel_in = '0;
  logic [9:0] po0;
  logic so0, fd0;
  logic [3:0] sc0;
  logic [19:0] po1;
  logic so1, fd1;
  logic [4:0] sc1;

  always #5 sysclk = ~sysclk;

  i4003x_shiftreg #(.WIDTH(10), .STAGES(1), .LATCHED(1'b1)) u0 (
    .sysclk(sysclk), .poc_n(poc_n), .cp(cp), .serial_in(serial_in), .dir(dir), .load(load),
    .parallel_in(parallel_in[9:0]), .strobe(strobe), .enable(enable),
    .parallel_out(po0), .serial_out(so0), .frame_done(fd0), .shift_count(sc0));

  i4003x_shiftreg #(.WIDTH(10), .STAGES(2), .LATCHED(1'b0)) u1 (
    .sysclk(sysclk), .poc_n(poc_n), .cp(cp), .serial_in(serial_in), .dir(dir), .load(load),
    .parallel_in(parallel_in), .strobe(strobe), .enable(enable),
    .parallel_out(po1), .serial_out(so1), .frame_done(fd1), .shift_count(sc1));

  typedef struct {
    logic [9:0] po0; logic so0, fd0; logic [3:0] sc0;
    logic [19:0] po1; logic so1, fd1; logic [4:0] sc1;
  } exp_t;

  exp_t sbq[$];
  exp_t m;
  int nv = 0, nm = 0;
  longint sr0 = 0, sr1 = 0, lat0 = 0;
  int cnt0 = 0, cnt1 = 0, cyc = 0;
  bit cp_last = 0;
  int due[$];
  bit g_si = 0, g_dir = 0, g_load = 0, g_st = 0, g_en = 1;
  logic [19:0] g_pin = '0;
  bit pat[10] = '{1, 0, 1, 1, 0, 0, 1, 0, 1, 1};

  function automatic void chk(string n, longint a, longint b);
    nv++;
    if (a != b) begin
      nm++;
      $display("FAIL %s: got %0h, expected %0h at %0t", n, a, b, $time);
    end
  endfunction

  function automatic longint shf(longint v, int n, bit si, bit d);
    return d ? ((v >> 1) | (longint'(si) << (n - 1)))
             : (((v << 1) | longint'(si)) & ((longint'(1) << n) - 1));
  endfunction

  // A cp fall first seen at edge k shifts the register at edge k+2.
  task automatic tick(input bit c);
    exp_t e;
    bit sh;
    bit f0, f1;
    f0 = 0;
    f1 = 0;
    @(negedge sysclk);
    cp = c; serial_in = g_si; dir = g_dir; load = g_load;
    parallel_in = g_pin; strobe = g_st; enable = g_en;
    cyc++;
    if (cp_last && !c) due.push_back(cyc + 2);
    cp_last = c;
    sh = due.size() > 0 && due[0] == cyc;
    if (sh) void'(due.pop_front());
    if (g_st) lat0 = sr0;
    if (g_load) begin
      sr0 = longint'(g_pin[9:0]);
      sr1 = longint'(g_pin);
      cnt0 = 0;
      cnt1 = 0;
    end else if (sh) begin
      sr0 = shf(sr0, 10, g_si, g_dir);
      sr1 = shf(sr1, 20, g_si, g_dir);
      cnt0++;
      cnt1++;
      if (cnt0 == 10) begin cnt0 = 0; f0 = 1; end
      if (cnt1 == 20) begin cnt1 = 0; f1 = 1; end
    end
    e.po0 = g_en ? lat0[9:0] : '0;
    e.so0 = g_dir ? sr0[0] : sr0[9];
    e.fd0 = f0;
    e.sc0 = cnt0[3:0];
    e.po1 = g_en ? sr1[19:0] : '0;
    e.so1 = g_dir ? sr1[0] : sr1[19];
    e.fd1 = f1;
    e.sc1 = cnt1[4:0];
    sbq.push_back(e);
  endtask

  task automatic pulse(input bit si, input bit d, input bit ld_last, input bit st_last);
    g_si = si;
    g_dir = d;
    tick(1); tick(1); tick(0); tick(0);
    g_load = ld_last;
    g_st = st_last;
    tick(0);
    g_load = 0;
    g_st = 0;
  endtask

  task automatic settle();
    @(posedge sysclk);
    #3;
  endtask

  initial forever begin
    @(posedge sysclk);
    #2;
    if (sbq.size() > 0) begin
      m = sbq.pop_front();
      chk("po0", po0, m.po0); chk("so0", so0, m.so0);
      chk("fd0", fd0, m.fd0); chk("sc0", sc0, m.sc0);
      chk("po1", po1, m.po1); chk("so1", so1, m.so1);
      chk("fd1", fd1, m.fd1); chk("sc1", sc1, m.sc1);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, nv=%0d nm=%0d", nv, nm);
    $fatal(1);
  end

  initial begin
    int hold;
    bit c;
    repeat (4) tick(0);
    poc_n = 1;
    repeat (6) tick(0);
    for (int i = 0; i < 10; i++) pulse(pat[i], 0, 0, 0);
    settle();
    chk("frame_done_10th", fd0, 1);
    chk("count_wrap", sc0, 0);
    g_st = 1;
    tick(0);
    g_st = 0;
    settle();
    chk("pattern_latched", po0, 10'b1011001011);
    chk("pattern_legacy", po1, 20'h002CB);

    g_pin = 20'h80001;
    g_load = 1;
    g_dir = 1;
    tick(0);
    g_load = 0;
    settle();
    chk("cascade_so_dir1", so1, 1);
    g_dir = 0;
    tick(0);
    #1;
    chk("cascade_so_dir0", so1, 1);
    pulse(0, 1, 0, 0);
    settle();
    chk("cascade_sr", po1, 20'h40000);
    chk("cascade_so", so1, 0);
    g_dir = 0;
    tick(0);
    #1;
    chk("cascade_so_bit19", so1, 0);

    g_pin = 20'h003FF;
    pulse(0, 0, 1, 0);
    settle();
    chk("prio_sr", po1, 20'h003FF);
    chk("prio_cnt0", sc0, 0);
    chk("prio_cnt1", sc1, 0);

    g_pin = 20'h00155;
    g_load = 1;
    tick(0);
    g_load = 0;
    pulse(1, 0, 0, 0);
    settle();
    chk("latch_hold", po0, 10'h2CB);
    pulse(1, 0, 0, 1);
    settle();
    chk("latch_pre_shift", po0, 10'h2AB);
    chk("legacy_track", po1, 20'h00557);
    g_en = 0;
    tick(0);
    #1;
    chk("enable_off0", po0, 0);
    chk("enable_off1", po1, 0);
    g_en = 1;

    repeat (3) pulse(1, 0, 0, 0);
    @(posedge sysclk);
    #5;
    poc_n = 0;
    cp = 0;
    #1;
    chk("rst_po0", po0, 0); chk("rst_so0", so0, 0); chk("rst_fd0", fd0, 0); chk("rst_sc0", sc0, 0);
    chk("rst_po1", po1, 0); chk("rst_so1", so1, 0); chk("rst_fd1", fd1, 0); chk("rst_sc1", sc1, 0);
    sr0 = 0; sr1 = 0; lat0 = 0; cnt0 = 0; cnt1 = 0;
    due.delete();
    cp_last = 0;
    repeat (3) tick(0);
    poc_n = 1;
    repeat (6) tick(0);
    pulse(0, 0, 0, 0);
    settle();
    chk("rst_first_cnt", sc0, 1);

    c = 0;
    hold = 2;
    repeat (2000) begin
      g_si = 1'($urandom);
      g_dir = ($urandom_range(0, 7) == 0) ? ~g_dir : g_dir;
      g_load = $urandom_range(0, 24) == 0;
      g_pin = 20'($urandom);
      g_st = $urandom_range(0, 3) == 0;
      g_en = $urandom_range(0, 4) != 0;
      tick(c);
      hold--;
      if (hold == 0) begin
        c = ~c;
        hold = $urandom_range(2, 4);
      end
    end
    g_load = 0;
    g_st = 0;
    repeat (4) tick(0);
    settle();
    settle();
    $display("== %0d vectors applied, %0d miscompares ==", nv, nm);
    $finish;
  end
endmodule
